// File: rtl/sync10010_tx_if.sv
// Handshake and serial-line bundle between a word producer and the 10010-sync transmitter.
// The producer side uses the master modport; the transmitter uses the slave modport.
interface sync10010_tx_if #(
   parameter int unsigned DATA_W = 8
);
   logic              bit_en;
   logic [DATA_W-1:0] din;
   logic              din_valid;
   logic              din_ready;
   logic              j;
   logic              stuff;
   logic              busy;
   logic              done;

   modport master (
      output bit_en, din, din_valid,
      input  din_ready, j, stuff, busy, done
   );

   modport slave (
      input  bit_en, din, din_valid,
      output din_ready, j, stuff, busy, done
   );
endinterface

// File: rtl/sync10010_tx.sv
// Serial frame transmitter: preamble 10010, then payload with stuff bits so the far-end
// 10010 detector fires only on the last preamble bit of each frame.
module sync10010_tx #(
   parameter int unsigned DATA_W    = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input logic           clk,
   input logic           rst,
   sync10010_tx_if.slave bus
);
   localparam int unsigned IdxW = $clog2(DATA_W);
   // Counter must also reach 4 during the preamble, even for tiny payloads.
   localparam int unsigned CntW = (IdxW + 1 < 3) ? 3 : IdxW + 1;

   typedef enum logic [2:0] {StIdle, StStart, StPre, StData, StTail} state_e;
   // Mirror of the far-end detector: A="", B="1", C="10", D="100", E="1001".
   typedef enum logic [2:0] {TrkA, TrkB, TrkC, TrkD, TrkE} trk_e;

   state_e            state_q, state_d;
   trk_e              trk_q, trk_d;
   trk_e              trk_after;
   logic              j_q, j_d;
   logic              stuff_q, stuff_d;
   logic              done_q, done_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [IdxW-1:0]   pay_idx;
   logic              pay_bit;
   logic              launch;
   logic              bit_v;
   logic              stuff_v;

   function automatic trk_e trk_next(input trk_e t, input logic b);
      trk_e n;
      n = TrkA;
      case (t)
         TrkA:    n = b ? TrkB : TrkA;
         TrkB:    n = b ? TrkB : TrkC;
         TrkC:    n = b ? TrkB : TrkD;
         TrkD:    n = b ? TrkE : TrkA;
         TrkE:    n = b ? TrkB : TrkC;
         default: n = TrkA;
      endcase
      return n;
   endfunction

   always_comb begin
      pay_idx   = MSB_FIRST ? (IdxW'(DATA_W - 1) - cnt_q[IdxW-1:0]) : cnt_q[IdxW-1:0];
      pay_bit   = data_q[pay_idx];
      trk_after = trk_next(trk_q, pay_bit);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trk_q   <= TrkA;
         j_q     <= 1'b0;
         stuff_q <= 1'b0;
         done_q  <= 1'b0;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         trk_q   <= trk_d;
         j_q     <= j_d;
         stuff_q <= stuff_d;
         done_q  <= done_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      trk_d   = trk_q;
      j_d     = j_q;
      stuff_d = stuff_q;
      done_d  = 1'b0;
      data_d  = data_q;
      cnt_d   = cnt_q;
      launch  = 1'b0;
      bit_v   = 1'b0;
      stuff_v = 1'b0;
      case (state_q)
         StIdle: begin
            launch = bus.bit_en;
            if (bus.din_valid) begin
               data_d  = bus.din;
               state_d = StStart;
            end
         end
         StStart: if (bus.bit_en) begin
            // Flush zeros until the far-end detector is back at its empty state.
            launch = 1'b1;
            if (trk_q == TrkA) begin
               bit_v   = 1'b1;
               state_d = StPre;
               cnt_d   = CntW'(1);
            end
         end
         StPre: if (bus.bit_en) begin
            launch = 1'b1;
            bit_v  = (cnt_q == CntW'(3));
            if (cnt_q == CntW'(4)) begin
               state_d = StData;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StData: if (bus.bit_en) begin
            launch = 1'b1;
            if (trk_q == TrkE && !pay_bit) begin
               bit_v   = 1'b1;
               stuff_v = 1'b1;
            end else begin
               bit_v = pay_bit;
               cnt_d = cnt_q + CntW'(1);
               if (cnt_q == CntW'(DATA_W - 1)) begin
                  if (trk_after == TrkE) begin
                     state_d = StTail;
                  end else begin
                     state_d = StIdle;
                     done_d  = 1'b1;
                  end
               end
            end
         end
         StTail: if (bus.bit_en) begin
            launch  = 1'b1;
            bit_v   = 1'b1;
            stuff_v = 1'b1;
            state_d = StIdle;
            done_d  = 1'b1;
         end
         default: state_d = StIdle;
      endcase
      if (launch) begin
         j_d     = bit_v;
         stuff_d = stuff_v;
         trk_d   = trk_next(trk_q, bit_v);
      end
   end

   always_comb begin
      bus.din_ready = (state_q == StIdle);
      bus.busy      = (state_q != StIdle);
      bus.j         = j_q;
      bus.stuff     = stuff_q;
      bus.done      = done_q;
   end
endmodule
